// File: rtl/fp_floor_iterative.sv
// Multi-cycle IEEE-754 single to signed 32-bit floor converter.
// The significand is shifted one bit per cycle toward the binary point; specials bypass the shifter.
module fp_floor_iterative (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] mag_r;
    logic        sticky_r;
    logic [4:0]  cnt_r;
    logic        dir_left_r;
    logic        sign_r;
    logic        special_r;
    logic [31:0] spec_out_r;
    logic        spec_ovf_r;
    logic        spec_unf_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] out_r;
    logic        ovf_r;
    logic        unf_r;

    logic        sign_s;
    logic [7:0]  exp_s;
    logic [22:0] frac_s;
    logic        special_s;
    logic [31:0] spec_out_s;
    logic        spec_ovf_s;
    logic        spec_unf_s;
    logic [7:0]  diff_s;
    logic [4:0]  cnt_s;
    logic        dir_left_s;
    logic [31:0] rounded_s;
    logic [31:0] normal_out_s;

    assign sign_s = in[31];
    assign exp_s  = in[30:23];
    assign frac_s = in[22:0];

    // Classify the operand and derive the fixed result or the shift plan.
    always_comb begin
        special_s  = 1'b0;
        spec_out_s = 32'h0000_0000;
        spec_ovf_s = 1'b0;
        spec_unf_s = 1'b0;
        diff_s     = 8'd0;
        dir_left_s = 1'b0;
        if (exp_s == 8'd255) begin
            special_s = 1'b1;
            if (frac_s != 23'd0) begin
                spec_out_s = 32'h7FFF_FFFF;
                spec_ovf_s = 1'b1;
            end else if (sign_s) begin
                spec_out_s = 32'h8000_0000;
                spec_unf_s = 1'b1;
            end else begin
                spec_out_s = 32'h7FFF_FFFF;
                spec_ovf_s = 1'b1;
            end
        end else if (exp_s < 8'd127) begin
            // |x| < 1: floor is 0 or -1; negative zero stays 0
            special_s = 1'b1;
            if (sign_s && ((exp_s != 8'd0) || (frac_s != 23'd0))) begin
                spec_out_s = 32'hFFFF_FFFF;
            end else begin
                spec_out_s = 32'h0000_0000;
            end
        end else if (exp_s >= 8'd158) begin
            special_s = 1'b1;
            if (!sign_s) begin
                spec_out_s = 32'h7FFF_FFFF;
                spec_ovf_s = 1'b1;
            end else begin
                spec_out_s = 32'h8000_0000;
                spec_unf_s = (in != 32'hCF00_0000);
            end
        end else if (exp_s > 8'd150) begin
            diff_s     = exp_s - 8'd150;
            dir_left_s = 1'b1;
        end else begin
            diff_s     = 8'd150 - exp_s;
            dir_left_s = 1'b0;
        end
    end

    assign cnt_s        = diff_s[4:0];
    assign rounded_s    = mag_r + {31'd0, sticky_r};
    assign normal_out_s = sign_r ? (32'd0 - rounded_s) : mag_r;

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            mag_r      <= 32'd0;
            sticky_r   <= 1'b0;
            cnt_r      <= 5'd0;
            dir_left_r <= 1'b0;
            sign_r     <= 1'b0;
            special_r  <= 1'b0;
            spec_out_r <= 32'd0;
            spec_ovf_r <= 1'b0;
            spec_unf_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            out_r      <= 32'd0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mag_r      <= {8'd0, 1'b1, frac_s};
                        sticky_r   <= 1'b0;
                        cnt_r      <= special_s ? 5'd0 : cnt_s;
                        dir_left_r <= dir_left_s;
                        sign_r     <= sign_s;
                        special_r  <= special_s;
                        spec_out_r <= spec_out_s;
                        spec_ovf_r <= spec_ovf_s;
                        spec_unf_r <= spec_unf_s;
                        busy_r     <= 1'b1;
                        if (special_s || (cnt_s == 5'd0)) begin
                            state_r <= FINAL;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (dir_left_r) begin
                        mag_r <= mag_r << 1;
                    end else begin
                        mag_r    <= mag_r >> 1;
                        sticky_r <= sticky_r | mag_r[0];
                    end
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1) begin
                        state_r <= FINAL;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                FINAL: begin
                    if (special_r) begin
                        out_r <= spec_out_r;
                        ovf_r <= spec_ovf_r;
                        unf_r <= spec_unf_r;
                    end else begin
                        out_r <= normal_out_s;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out       = out_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;

    fp_floor_iterative_checker u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy_r),
        .done      (done_r),
        .overflow  (ovf_r),
        .underflow (unf_r)
    );

endmodule

// Handshake and flag invariants for fp_floor_iterative.
module fp_floor_iterative_checker (
    input logic clk,
    input logic rst_n,
    input logic busy,
    input logic done,
    input logic overflow,
    input logic underflow
);

    a_done_single : assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_busy_done   : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
    a_flags_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(overflow && underflow));

endmodule

// File: tb/tb_fp_floor_iterative.sv
// Directed bench for fp_floor_iterative: results, flags, latency and handshake corners.
module tb_fp_floor_iterative;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        overflow;
    logic        underflow;

    int errors;
    int checks;

    fp_floor_iterative dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Counts sampled cycles (and busy cycles) until done, bounded.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] val, input logic [31:0] exp_out,
                          input logic exp_ovf, input logic exp_unf, input int n);
        int lat;
        int bcnt;
        @(negedge clk);
        in    = val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check({tag, "_lat"}, lat, n + 1);
        check({tag, "_busy"}, bcnt, n + 1);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_flags"}, {30'd0, overflow, underflow}, {30'd0, exp_ovf, exp_unf});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        in     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        rst_n = 1'b1;

        run_op("pi",        32'h40490FDB, 32'h0000_0003, 1'b0, 1'b0, 22);
        run_op("neg2p5",    32'hC0200000, 32'hFFFF_FFFD, 1'b0, 1'b0, 22);
        run_op("neg0p5",    32'hBF000000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op("negzero",   32'h80000000, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_op("e23",       32'h4B000001, 32'h0080_0001, 1'b0, 1'b0, 0);
        run_op("e30",       32'h4EFFFFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 7);
        run_op("one",       32'h3F800000, 32'h0000_0001, 1'b0, 1'b0, 23);
        run_op("neg1p5",    32'hBFC00000, 32'hFFFF_FFFE, 1'b0, 1'b0, 23);
        run_op("nege23",    32'hCB000001, 32'hFF7F_FFFF, 1'b0, 1'b0, 0);
        run_op("pos_denorm",32'h00000001, 32'h0000_0000, 1'b0, 1'b0, 0);
        run_op("neg_denorm",32'h80000001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        run_op("ovf2p31",   32'h4F000000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
        run_op("neg2p31",   32'hCF000000, 32'h8000_0000, 1'b0, 1'b0, 0);
        run_op("unf",       32'hCF000001, 32'h8000_0000, 1'b0, 1'b1, 0);
        run_op("nan",       32'h7FC00000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
        run_op("pinf",      32'h7F800000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0);
        run_op("ninf",      32'hFF800000, 32'h8000_0000, 1'b0, 1'b1, 0);

        // start held high with a changing operand while busy
        @(negedge clk);
        in    = 32'h40490FDB;
        start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            in = 32'h4F000000 + lat;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("hold_lat", lat, 23);
        check("hold_out", out, 32'h0000_0003);
        @(negedge clk);
        check("hold_no_restart", {30'd0, busy, done}, 32'd0);

        // back-to-back: second start in the done cycle
        @(negedge clk);
        in    = 32'h4B000001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b_first_out", out, 32'h0080_0001);
        in    = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt);
        check("b2b_second_lat", lat, 24);
        check("b2b_second_out", out, 32'h0000_0001);

        // asynchronous reset during SHIFT
        @(negedge clk);
        in    = 32'hC0200000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out", out, 32'd0);
        check("midrst_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);

        run_op("after_rst", 32'hC0200000, 32'hFFFF_FFFD, 1'b0, 1'b0, 22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
